// File: rtl/gate_not_checker_pkg.sv
// Shared definitions for the NOT-gate response checker and its stimulus driver:
// state encoding, default run parameters and the per-sample compare helper.
package gate_not_checker_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ARMED  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam int TEST_NUMBER_DEF = 5;
  localparam int SETTLE_DEF      = 1;
  localparam int CNT_W_DEF       = 8;

  // Both gate forms must equal ~s; case-equality makes an X/Z output a failure.
  function automatic logic sample_ok(input logic s, input logic lo, input logic inst);
    return (lo === ~s) && (inst === ~s);
  endfunction

endpackage

// File: rtl/gate_not_checker_settle_timer.sv
// Settle-time down-counter: load on sample acceptance, expire_o high while the
// count sits at 1 (the compare cycle), then it drains to 0.
module gate_not_checker_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int TW = $clog2(SETTLE + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: reload, count down, or rest at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = TW'(SETTLE);
    end else if (count_q != {TW{1'b0}}) begin
      count_d = count_q - TW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {TW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == TW'(1));

endmodule

// File: rtl/gate_not_checker.sv
// Response checker for a NOT-gate DUT: accepts TEST_NUMBER samples per run, compares
// both gate forms after SETTLE cycles and reports counts plus a sticky verdict.
module gate_not_checker
  import gate_not_checker_pkg::*;
#(
  parameter int TEST_NUMBER = TEST_NUMBER_DEF,
  parameter int SETTLE      = SETTLE_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sample_valid_i,
  input  logic             signal_i,
  input  logic             not_logic_i,
  input  logic             not_instance_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] sample_count_o,
  output logic             overrun_o,
  output logic             toggle_err_o
);

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic             overrun_q, overrun_d;
  logic             toggle_err_q, toggle_err_d;
  logic             mismatch_q, mismatch_d;

  logic start_ok_s;
  logic accept_s;
  logic expire_s;
  logic cmp_s;
  logic last_s;

  assign start_ok_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept_s   = (state_q == ST_ARMED) && sample_valid_i;
  assign cmp_s      = (state_q == ST_SETTLE) && expire_s;
  assign last_s     = (sample_count_q == CNT_W'(TEST_NUMBER - 1));

  gate_not_checker_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept_s),
    .expire_o (expire_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start_i ? ST_ARMED : ST_IDLE;
      ST_ARMED:  state_d = sample_valid_i ? ST_SETTLE : ST_ARMED;
      ST_SETTLE: begin
        if (expire_s) begin
          state_d = last_s ? ST_DONE : ST_ARMED;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_DONE:   state_d = start_i ? ST_ARMED : ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM status outputs decoded from the state register.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      ST_ARMED:  busy_o = 1'b1;
      ST_SETTLE: busy_o = 1'b1;
      ST_DONE:   done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Sample latch, saturating counters and sticky flags.
  always_comb begin
    s_d            = s_q;
    err_count_d    = err_count_q;
    sample_count_d = sample_count_q;
    overrun_d      = overrun_q;
    toggle_err_d   = toggle_err_q;
    mismatch_d     = 1'b0;
    if (start_ok_s) begin
      s_d            = 1'b0;
      err_count_d    = {CNT_W{1'b0}};
      sample_count_d = {CNT_W{1'b0}};
      overrun_d      = 1'b0;
      toggle_err_d   = 1'b0;
    end else begin
      if (accept_s) begin
        s_d = signal_i;
        if ((sample_count_q != {CNT_W{1'b0}}) && (signal_i == s_q)) begin
          toggle_err_d = 1'b1;
        end else begin
          toggle_err_d = toggle_err_q;
        end
      end else begin
        s_d = s_q;
      end
      if ((state_q == ST_SETTLE) && sample_valid_i) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      if (cmp_s) begin
        sample_count_d = (sample_count_q == {CNT_W{1'b1}}) ? sample_count_q
                                                          : sample_count_q + CNT_W'(1);
        if (!sample_ok(s_q, not_logic_i, not_instance_i)) begin
          mismatch_d  = 1'b1;
          err_count_d = (err_count_q == {CNT_W{1'b1}}) ? err_count_q
                                                      : err_count_q + CNT_W'(1);
        end else begin
          mismatch_d  = 1'b0;
        end
      end else begin
        sample_count_d = sample_count_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q            <= 1'b0;
      err_count_q    <= {CNT_W{1'b0}};
      sample_count_q <= {CNT_W{1'b0}};
      overrun_q      <= 1'b0;
      toggle_err_q   <= 1'b0;
      mismatch_q     <= 1'b0;
    end else begin
      s_q            <= s_d;
      err_count_q    <= err_count_d;
      sample_count_q <= sample_count_d;
      overrun_q      <= overrun_d;
      toggle_err_q   <= toggle_err_d;
      mismatch_q     <= mismatch_d;
    end
  end

  assign err_count_o    = err_count_q;
  assign sample_count_o = sample_count_q;
  assign overrun_o      = overrun_q;
  assign toggle_err_o   = toggle_err_q;
  assign mismatch_o     = mismatch_q;
  assign pass_o         = (state_q == ST_DONE) && (err_count_q == {CNT_W{1'b0}})
                          && !overrun_q && !toggle_err_q;

endmodule

// File: tb/tb_gate_not_checker.sv
// Bench for gate_not_checker: a SETTLE=1 instance driven from a vector table with a
// scoreboard on compare results, and a SETTLE=3 instance for the overrun case.
module tb_gate_not_checker;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start_a = 1'b0, valid_a = 1'b0, sig_a = 1'b0, stuck_a = 1'b0;
  logic nl_a, ni_a;
  logic busy_a, done_a, pass_a, mis_a, ovr_a, tog_a;
  logic [7:0] ecnt_a, scnt_a;

  logic start_b = 1'b0, valid_b = 1'b0, sig_b = 1'b0;
  logic nl_b, ni_b;
  logic busy_b, done_b, pass_b, mis_b, ovr_b, tog_b;
  logic [7:0] ecnt_b, scnt_b;

  // Behavioural NOT-gate DUT, with a stuck-at-0 fault option on the instance form.
  assign nl_a = ~sig_a;
  assign ni_a = stuck_a ? 1'b0 : ~sig_a;
  assign nl_b = ~sig_b;
  assign ni_b = ~sig_b;

  gate_not_checker #(.TEST_NUMBER(5), .SETTLE(SETTLE_A), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .sample_valid_i(valid_a),
    .signal_i(sig_a), .not_logic_i(nl_a), .not_instance_i(ni_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .mismatch_o(mis_a),
    .err_count_o(ecnt_a), .sample_count_o(scnt_a), .overrun_o(ovr_a),
    .toggle_err_o(tog_a)
  );

  gate_not_checker #(.TEST_NUMBER(5), .SETTLE(SETTLE_B), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .sample_valid_i(valid_b),
    .signal_i(sig_b), .not_logic_i(nl_b), .not_instance_i(ni_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .mismatch_o(mis_b),
    .err_count_o(ecnt_b), .sample_count_o(scnt_b), .overrun_o(ovr_b),
    .toggle_err_o(tog_b)
  );

  always #5 clk = ~clk;

  typedef struct { logic sig; logic stuck; logic exp_mis; } vec_t;
  typedef struct { int due; logic mis; int cnt; int err; } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   model_cnt = 0;
  int   model_err = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_run_a();
    start_a   = 1'b1;
    model_cnt = 0;
    model_err = 0;
    @(posedge clk); #1;
    start_a   = 1'b0;
  endtask

  task automatic drive_a(input logic s, input logic stuck, input logic exp_mis);
    sig_a   = s;
    stuck_a = stuck;
    valid_a = 1'b1;
    model_cnt++;
    if (exp_mis) model_err++;
    sb.push_back('{due: cyc + SETTLE_A + 2, mis: exp_mis, cnt: model_cnt, err: model_err});
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (SETTLE_A) begin @(posedge clk); #1; end
  endtask

  task automatic drive_b(input logic s);
    sig_b   = s;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    repeat (SETTLE_B) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: pops each expected compare result on its due cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          n_checks++;
          n_err++;
          $display("FAIL sb_stale: entry due %0d still queued at %0d", e.due, cyc);
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          chk("mismatch", 32'(mis_a), 32'(e.mis));
          chk("sample_count", 32'(scnt_a), 32'(e.cnt));
          chk("err_count", 32'(ecnt_a), 32'(e.err));
        end else begin
          chk("mismatch_quiet", 32'(mis_a), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vecs[0] = '{1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 32'({busy_a, done_a, pass_a, mis_a, ecnt_a, scnt_a, ovr_a, tog_a}), 32'd0);
    chk("reset_b", 32'({busy_b, done_b, pass_b, mis_b, ecnt_b, scnt_b, ovr_b, tog_b}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Correct DUT run, then a run with not_instance stuck at 0.
    for (int r = 0; r < 2; r++) begin
      start_run_a();
      chk("busy_after_start", 32'(busy_a), 32'd1);
      for (int i = 0; i < 5; i++) begin
        drive_a(vecs[r*5+i].sig, vecs[r*5+i].stuck, vecs[r*5+i].exp_mis);
      end
      chk("done", 32'(done_a), 32'd1);
      chk("busy_done", 32'(busy_a), 32'd0);
      chk("final_samples", 32'(scnt_a), 32'd5);
      chk("final_errs", 32'(ecnt_a), 32'(model_err));
      chk("pass", 32'(pass_a), 32'((model_err == 0) ? 1 : 0));
    end
    stuck_a = 1'b0;

    // Repeated value trips the toggle rule.
    start_run_a();
    drive_a(1'b0, 1'b0, 1'b0);
    chk("toggle_first", 32'(tog_a), 32'd0);
    drive_a(1'b0, 1'b0, 1'b0);
    chk("toggle_second", 32'(tog_a), 32'd1);
    drive_a(1'b1, 1'b0, 1'b0);
    drive_a(1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0);
    chk("toggle_done", 32'(done_a), 32'd1);
    chk("toggle_errs", 32'(ecnt_a), 32'd0);
    chk("toggle_pass", 32'(pass_a), 32'd0);

    // Reset in the middle of SETTLE, then an unarmed sample.
    start_run_a();
    drive_a(1'b0, 1'b0, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0);
    sig_a = 1'b0; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_reset", 32'({busy_a, done_a, pass_a, mis_a, ecnt_a, scnt_a, ovr_a, tog_a}), 32'd0);
    sig_a = 1'b1; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_ignore_count", 32'(scnt_a), 32'd0);
    chk("idle_ignore_busy", 32'(busy_a), 32'd0);

    // Restart from DONE with a simultaneous sample that must be dropped.
    start_run_a();
    for (int i = 0; i < 5; i++) drive_a(vecs[i].sig, vecs[i].stuck, vecs[i].exp_mis);
    chk("pre_restart_done", 32'(done_a), 32'd1);
    start_a = 1'b1; valid_a = 1'b1; sig_a = 1'b1;
    model_cnt = 0; model_err = 0;
    @(posedge clk); #1;
    start_a = 1'b0; valid_a = 1'b0;
    chk("restart_done_low", 32'(done_a), 32'd0);
    chk("restart_busy", 32'(busy_a), 32'd1);
    chk("restart_cleared", 32'(scnt_a), 32'd0);
    for (int i = 0; i < 5; i++) drive_a(vecs[i].sig, vecs[i].stuck, vecs[i].exp_mis);
    chk("rerun_done", 32'(done_a), 32'd1);
    chk("rerun_samples", 32'(scnt_a), 32'd5);
    chk("rerun_pass", 32'(pass_a), 32'd1);

    // SETTLE=3 instance: back-to-back sample_valid causes overrun.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    sig_b = 1'b0; valid_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("ovr_not_yet", 32'(ovr_b), 32'd0);
      if (k == 1) chk("ovr_set", 32'(ovr_b), 32'd1);
    end
    valid_b = 1'b0;
    chk("ovr_one_sample", 32'(scnt_b), 32'd1);
    drive_b(1'b1);
    drive_b(1'b0);
    drive_b(1'b1);
    drive_b(1'b0);
    chk("ovr_done", 32'(done_b), 32'd1);
    chk("ovr_samples", 32'(scnt_b), 32'd5);
    chk("ovr_errs", 32'(ecnt_b), 32'd0);
    chk("ovr_sticky", 32'(ovr_b), 32'd1);
    chk("ovr_pass", 32'(pass_b), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
